// File: rtl/mem_bus_pkg.sv
// Shared definitions for the lab memory-mapped bus: command encodings,
// default bus widths and the copy-engine state type.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_WR,
    S_DONE
  } dma_state_t;

endpackage

// File: rtl/mem_copy_dma.sv
// Second bus master that copies len words from src_addr to dst_addr,
// three bus cycles per word (read, read-capture, write).
module mem_copy_dma
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  dma_state_t        state_q;
  logic [ADDR_W-1:0] sa_q, da_q, cnt_q;
  logic [DATA_W-1:0] wdat_q;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q, done_q;

  logic [ADDR_W-1:0] sa_d, da_d, cnt_d;

  // Modulo arithmetic: wrap past the top of the address space is silent.
  always_comb begin
    sa_d  = sa_q + ADDR_W'(1);
    da_d  = da_q + ADDR_W'(1);
    cnt_d = cnt_q - ADDR_W'(1);
  end

  // Bus outputs are registered alongside the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      da_q    <= '0;
      cnt_q   <= '0;
      wdat_q  <= '0;
      cmd_q   <= MNONE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_q  <= MNONE;
          addr_q <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            sa_q   <= src_addr;
            da_q   <= dst_addr;
            cnt_q  <= len;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RD1;
              cmd_q   <= MREAD;
              addr_q  <= src_addr;
            end
          end
        end
        S_RD1: begin
          state_q <= S_RD2;
          cmd_q   <= MREAD;
          addr_q  <= sa_q;
        end
        S_RD2: begin
          wdat_q  <= read_data;
          sa_q    <= sa_d;
          cnt_q   <= cnt_d;
          state_q <= S_WR;
          cmd_q   <= MWRITE;
          addr_q  <= da_q;
        end
        S_WR: begin
          da_q <= da_d;
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            cmd_q   <= MNONE;
            addr_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RD1;
            cmd_q   <= MREAD;
            addr_q  <= sa_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cmd_q   <= MNONE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cmd_q   <= MNONE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_cmd    = cmd_q;
  assign mem_addr   = addr_q;
  assign write_data = wdat_q;

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Bus-initiator copy engine for the lab memory-mapped system. On a start pulse it reads `len` consecutive 16-bit words from `src_addr` and writes them to `dst_addr` using the shared `mem_cmd`/`mem_addr`/`read_data`/`write_data` bus. It drives the same bus, as initiator, that the RAM and the LED/switch decode respond to. It sits beside the CPU as a second bus master; external arbitration guarantees the CPU drives `MNONE` while `busy` is high.

## Interface
- `ADDR_W`, 9, memory address width (512-word space).
- `DATA_W`, 16, data word width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` input 1: request a copy; sampled only in IDLE.
- `src_addr` input ADDR_W: first source word address; captured when `start` is accepted.
- `dst_addr` input ADDR_W: first destination word address; captured when `start` is accepted.
- `len` input ADDR_W: number of words to copy, 0–511; captured when `start` is accepted.
- `busy` output 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` output 1: one-cycle pulse on completion.
- `mem_cmd` output 2: bus command, one of `MNONE`=00, `MREAD`=01, `MWRITE`=10.
- `mem_addr` output ADDR_W: bus address.
- `write_data` output DATA_W: bus write data.
- `read_data` input DATA_W: bus read data from the responders.

## Operation
- FSM states: IDLE, RD1, RD2, WR, DONE.
- IDLE:
  - Outputs: `mem_cmd`=MNONE, `mem_addr`=0, `busy`=0.
  - On `start`=1: latch `src_addr`, `dst_addr`, `len` into `sa`, `da`, `cnt`.
  - If `len`=0, go to DONE; otherwise go to RD1.
- RD1: drive `mem_cmd`=MREAD and `mem_addr`=`sa`. This is the RAM registered-read cycle. Go to RD2.
- RD2:
  - Keep MREAD and `mem_addr`=`sa`.
  - At the end of the cycle, latch `read_data` into `wdat`, increment `sa`, decrement `cnt`. Go to WR.
- WR:
  - Drive `mem_cmd`=MWRITE, `mem_addr`=`da`, `write_data`=`wdat`.
  - At the end of the cycle, increment `da`.
  - If `cnt`=0 go to DONE, else go to RD1.
- DONE: `mem_cmd`=MNONE, `done`=1, `busy`=1. Go to IDLE unconditionally.
- `write_data` always reflects `wdat`. `wdat` holds its value outside WR.
- Address arithmetic is ADDR_W-bit modulo: 9'h1FF + 1 = 9'h000. Wrap is silent.
- Copy order is ascending. An overlapping region with `dst_addr` > `src_addr` is not protected; the result is a forward smear, and that is by design.
- The I/O addresses are plain addresses to this block: 9'h140 reads switches, 9'h100 writes LEDs.
- `start` in any state other than IDLE is ignored, including DONE. It is not queued.

## Timing
- Reset values: state=IDLE, `mem_cmd`=MNONE, `mem_addr`=0, `write_data`=0, `busy`=0, `done`=0.
- Internal reset values: `sa`, `da`, `cnt`, `wdat` all 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `read_data` or `start` to any output.
- Per-word cost is 3 cycles (RD1, RD2, WR).
- Let cycle 0 be the cycle in which `start` is sampled high. Then:
  - `done` is high in cycle 3·len+1.
  - `busy` is high in cycles 1..3·len+1.
  - For `len`=0, `done` is high in cycle 1 with no bus traffic.
- `read_data` is sampled only at the end of RD2, i.e. the second consecutive MREAD cycle at an unchanged address.
- Reset low mid-transfer: the next edge forces IDLE and MNONE. A partially completed copy is abandoned, with no `done` pulse. Words already written stay written.
- Reset and `start` in the same cycle: reset wins.

## Structure
- Shared package `mem_bus_pkg` holds:
  - the `MNONE`/`MREAD`/`MWRITE` localparams, replacing the current backtick defines;
  - the `dma_state_t` enum;
  - the `ADDR_W`/`DATA_W` defaults.
- `mem_copy_dma` imports this package. The top-level decode and the CPU migrate to it.
- Single module: one FSM, two address registers, one count register, one data register. No sub-module.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → all outputs at their reset values. Release with `start`=0 → IDLE, MNONE for 10 cycles.
- Basic copy: RAM[0x010..0x012]=16'hA5A5, 16'h1234, 16'hFFFF; start with src=0x010, dst=0x020, len=3.
  - `done` in cycle 10; `busy` high in cycles 1–10.
  - RAM[0x020..0x022] matches the source.
  - Bus sequence is R,R,W ×3.
- Zero length: len=0 → `done` in cycle 1; `mem_cmd`=MNONE throughout.
- I/O path: SW=8'h5C; src=0x140, dst=0x100, len=1 → `write_data`=16'h005C in the WR cycle; LEDR=8'h5C after cycle 3.
- Wrap: src=0x1FE, dst=0x0FE, len=4.
  - Read addresses 1FE, 1FF, 000, 001.
  - Write addresses 0FE, 0FF, 100, 101.
  - `done` in cycle 13.
- Abort and ignore:
  - Assert `reset`=0 in cycle 5 of a len=5 copy → IDLE next edge, no `done` pulse.
  - Separately, pulse `start` during RD2 and DONE → no effect; exactly one `done` per accepted start.
